// File: rtl/ddr2_resp_pkg.sv
// rtl/ddr2_resp_pkg.sv - shared encodings and FSM states for the DDR2 app-side responder
package ddr2_resp_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int ADDR_WORD_MSB = 31;
  localparam int ADDR_CMD_LSB  = 32;
  localparam int ADDR_CMD_MSB  = 34;
  localparam int ADDR_RSVD_BIT = 35;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WR,
    RD
  } resp_state_e;

endpackage

// File: rtl/ddr2_resp_fifo.sv
// rtl/ddr2_resp_fifo.sv - show-ahead synchronous FIFO with occupancy count and overflow pulse
module ddr2_resp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push    = push_i && (!full_o || do_pop);
  assign overflow_o = push_i && !do_push;
  assign dout_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr2_app_responder.sv
// rtl/ddr2_app_responder.sv - behavioural DDR2 app-interface slave with internal word memory
// Optional byte-mask storage in the WDF: DDR2_RESP_MASK_EN.
module ddr2_app_responder
  import ddr2_resp_pkg::*;
#(
  parameter int DQ_WIDTH   = 8,
  parameter int DM_WIDTH   = 1,
  parameter int MEM_AW     = 8,
  parameter int AF_DEPTH   = 16,
  parameter int WDF_DEPTH  = 32,
  parameter int AF_THRESH  = 4,
  parameter int WDF_THRESH = 8,
  parameter int RD_LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              burst_length_div2,
  input  logic [35:0]             app_af_addr,
  input  logic                    app_af_wren,
  input  logic [2*DQ_WIDTH-1:0]   app_wdf_data,
  input  logic [2*DM_WIDTH-1:0]   app_mask_data,
  input  logic                    app_wdf_wren,
  output logic                    af_almost_full,
  output logic                    wdf_almost_full,
  output logic                    read_data_valid,
  output logic [2*DQ_WIDTH-1:0]   read_data_fifo_out,
  output logic                    init_done,
  output logic                    overflow_err
);

  localparam int DW     = 2 * DQ_WIDTH;
  localparam int MW     = 2 * DM_WIDTH;
  localparam int AFW    = 3 + MEM_AW;
  localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
  localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;
  localparam logic [AF_CW-1:0]  AF_LIMIT  = AF_CW'(AF_DEPTH - AF_THRESH);
  localparam logic [WDF_CW-1:0] WDF_LIMIT = WDF_CW'(WDF_DEPTH - WDF_THRESH);
`ifdef DDR2_RESP_MASK_EN
  localparam int WDF_W = DW + MW;
`else
  localparam int WDF_W = DW;
`endif

  resp_state_e       state_q;
  logic [MEM_AW-1:0] init_idx_q;
  logic [MEM_AW-1:0] addr_q;
  logic [2:0]        beats_q;
  logic [2:0]        off_q;
  logic              init_done_q;

  logic [AFW-1:0]    af_dout;
  logic [AF_CW-1:0]  af_count;
  logic              af_empty, af_full_unused, af_ovf, af_pop;
  logic [WDF_W-1:0]  wdf_din, wdf_dout;
  logic [WDF_CW-1:0] wdf_count;
  logic              wdf_empty, wdf_full_unused, wdf_ovf, wdf_pop;

  logic [2:0]        af_cmd;
  logic [MEM_AW-1:0] mem_idx;
  logic [DW-1:0]     wr_data;
  logic [MW-1:0]     wr_mask;
  logic              issue;
  logic              unused_in_bits;

  logic [DW-1:0]     mem_q [2**MEM_AW];
  logic              dl_vld_q [RD_LATENCY];
  logic [MEM_AW-1:0] dl_idx_q [RD_LATENCY];
  logic              rd_vld_q;
  logic [DW-1:0]     rd_data_q;
  logic              af_afull_q, wdf_afull_q, ovf_q;
  logic              af_afull_d, wdf_afull_d, ovf_d;

  ddr2_resp_fifo #(.DEPTH(AF_DEPTH), .WIDTH(AFW)) u_af (
    .clk(clk), .reset_n(reset_n),
    .push_i(app_af_wren),
    .din_i({app_af_addr[ADDR_CMD_MSB:ADDR_CMD_LSB], app_af_addr[MEM_AW-1:0]}),
    .pop_i(af_pop), .dout_o(af_dout), .count_o(af_count),
    .full_o(af_full_unused), .empty_o(af_empty), .overflow_o(af_ovf)
  );

  ddr2_resp_fifo #(.DEPTH(WDF_DEPTH), .WIDTH(WDF_W)) u_wdf (
    .clk(clk), .reset_n(reset_n),
    .push_i(app_wdf_wren), .din_i(wdf_din),
    .pop_i(wdf_pop), .dout_o(wdf_dout), .count_o(wdf_count),
    .full_o(wdf_full_unused), .empty_o(wdf_empty), .overflow_o(wdf_ovf)
  );

`ifdef DDR2_RESP_MASK_EN
  assign wdf_din        = {app_mask_data, app_wdf_data};
  assign wr_mask        = wdf_dout[DW +: MW];
  assign unused_in_bits = ^{app_af_addr[ADDR_RSVD_BIT], app_af_addr[ADDR_WORD_MSB:MEM_AW]};
`else
  assign wdf_din        = app_wdf_data;
  assign wr_mask        = '0;
  assign unused_in_bits = ^{app_af_addr[ADDR_RSVD_BIT], app_af_addr[ADDR_WORD_MSB:MEM_AW],
                            app_mask_data};
`endif

  assign wr_data = wdf_dout[DW-1:0];
  assign af_cmd  = af_dout[AFW-1 -: 3];
  assign af_pop  = (state_q == IDLE) && !af_empty;
  assign wdf_pop = (state_q == WR) && !wdf_empty;
  assign issue   = (state_q == RD);
  assign mem_idx = addr_q + MEM_AW'(off_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      beats_q     <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == '1) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (!af_empty) begin
            addr_q  <= af_dout[MEM_AW-1:0];
            beats_q <= burst_length_div2;
            off_q   <= '0;
            if (af_cmd == CMD_WRITE)     state_q <= WR;
            else if (af_cmd == CMD_READ) state_q <= RD;
          end
        end
        WR: begin
          if (!wdf_empty) begin
            off_q   <= off_q + 1'b1;
            beats_q <= beats_q - 1'b1;
            if (beats_q <= 3'd1) state_q <= IDLE;
          end
        end
        RD: begin
          off_q   <= off_q + 1'b1;
          beats_q <= beats_q - 1'b1;
          if (beats_q <= 3'd1) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_idx_q] <= '0;
    end else if (wdf_pop) begin
      for (int b = 0; b < MW; b++) begin
        if (!wr_mask[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign af_afull_d  = (af_count >= AF_LIMIT);
  assign wdf_afull_d = (wdf_count >= WDF_LIMIT);
  assign ovf_d       = ovf_q || af_ovf || wdf_ovf;

  // Memory is read at the tail of the delay line so earlier writes are always visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_idx_q[i] <= '0;
      end
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      af_afull_q  <= 1'b1;
      wdf_afull_q <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      dl_vld_q[0] <= issue;
      dl_idx_q[0] <= mem_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_idx_q[i] <= dl_idx_q[i-1];
      end
      rd_vld_q <= dl_vld_q[RD_LATENCY-1];
      if (dl_vld_q[RD_LATENCY-1]) rd_data_q <= mem_q[dl_idx_q[RD_LATENCY-1]];
      af_afull_q  <= af_afull_d;
      wdf_afull_q <= wdf_afull_d;
      ovf_q       <= ovf_d;
    end
  end

  assign af_almost_full     = af_afull_q;
  assign wdf_almost_full    = wdf_afull_q;
  assign read_data_valid    = rd_vld_q;
  assign read_data_fifo_out = rd_data_q;
  assign init_done          = init_done_q;
  assign overflow_err       = ovf_q;

endmodule

// File: tb/tb_ddr2_app_responder.sv
// tb/tb_ddr2_app_responder.sv - directed self-checking bench for ddr2_app_responder
module tb_ddr2_app_responder;
  import ddr2_resp_pkg::*;

  localparam int RD_LAT = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  burst_length_div2;
  logic [35:0] app_af_addr;
  logic        app_af_wren;
  logic [15:0] app_wdf_data;
  logic [1:0]  app_mask_data;
  logic        app_wdf_wren;
  logic        af_almost_full, wdf_almost_full, read_data_valid, init_done, overflow_err;
  logic [15:0] read_data_fifo_out;

  int total = 0;
  int bad   = 0;

  ddr2_app_responder #(
    .DQ_WIDTH(8), .DM_WIDTH(1), .MEM_AW(8), .AF_DEPTH(16), .WDF_DEPTH(32),
    .AF_THRESH(4), .WDF_THRESH(8), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .burst_length_div2(burst_length_div2),
    .app_af_addr(app_af_addr), .app_af_wren(app_af_wren),
    .app_wdf_data(app_wdf_data), .app_mask_data(app_mask_data), .app_wdf_wren(app_wdf_wren),
    .af_almost_full(af_almost_full), .wdf_almost_full(wdf_almost_full),
    .read_data_valid(read_data_valid), .read_data_fifo_out(read_data_fifo_out),
    .init_done(init_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] bl,
                          input logic [15:0] d0, d1, d2, d3, input logic [1:0] m);
    logic [15:0] d [4];
    d = '{d0, d1, d2, d3};
    burst_length_div2 = bl;
    app_af_addr = {1'b0, CMD_WRITE, addr};
    app_af_wren = 1'b1;
    for (int i = 0; i < int'(bl); i++) begin
      app_wdf_data  = d[i];
      app_mask_data = m;
      app_wdf_wren  = 1'b1;
      @(negedge clk);
      app_af_wren = 1'b0;
    end
    app_wdf_wren = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] bl,
                         input logic [15:0] e0, e1, e2, e3);
    logic [15:0] e [4];
    logic [15:0] got [8];
    int n, first, last;
    e = '{e0, e1, e2, e3};
    n = 0; first = -1; last = -1;
    burst_length_div2 = bl;
    app_af_addr = {1'b0, CMD_READ, addr};
    app_af_wren = 1'b1;
    @(negedge clk);
    app_af_wren = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (read_data_valid) begin
        if (first < 0) first = c;
        last = c;
        if (n < 8) got[n] = read_data_fifo_out;
        n++;
      end
    end
    check({tag, "_lat"}, first, RD_LAT + 2);
    check({tag, "_beats"}, n, {29'd0, bl});
    check({tag, "_contig"}, last - first + 1, n);
    for (int i = 0; i < int'(bl) && i < 4; i++) check({tag, "_data"}, {16'd0, got[i]}, {16'd0, e[i]});
  endtask

  initial begin
    logic [16:0] vmask;
    logic [15:0] d8, d9, d11, d12;
    int beats;

    reset_n = 1'b1;
    burst_length_div2 = 3'd2;
    app_af_addr = '0; app_af_wren = 1'b0;
    app_wdf_data = '0; app_mask_data = '0; app_wdf_wren = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_rdv", read_data_valid, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_data", read_data_fifo_out, 0);
    check("rst_af_afull", af_almost_full, 1);
    check("rst_wdf_afull", wdf_almost_full, 1);

    reset_n = 1'b1;
    repeat (255) @(negedge clk);
    check("init_255", init_done, 0);
    check("af_afull_idle", af_almost_full, 0);
    @(negedge clk);
    check("init_256", init_done, 1);

    // unknown command is discarded, then a read of never-written memory
    app_af_addr = {1'b0, 3'b011, 32'h20};
    app_af_wren = 1'b1;
    @(negedge clk);
    app_af_wren = 1'b0;
    repeat (3) @(negedge clk);
    do_read("rd_zero", 32'h10, 3'd2, 16'h0, 16'h0, 16'h0, 16'h0);

    do_write(32'h20, 3'd2, 16'hAA11, 16'hBB22, 16'h0, 16'h0, 2'b00);
    do_read("rd_bl4", 32'h20, 3'd2, 16'hAA11, 16'hBB22, 16'h0, 16'h0);

    do_write(32'hFF, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00);
    do_read("rd_wrap", 32'hFF, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    do_read("rd_low", 32'h100, 3'd2, 16'h2222, 16'h3333, 16'h0, 16'h0);

    do_write(32'h40, 3'd2, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 2'b00);
    do_write(32'h40, 3'd2, 16'h1234, 16'h1234, 16'h0, 16'h0, 2'b10);
`ifdef DDR2_RESP_MASK_EN
    do_read("rd_mask", 32'h40, 3'd2, 16'hFF34, 16'hFF34, 16'h0, 16'h0);
`else
    do_read("rd_mask", 32'h40, 3'd2, 16'h1234, 16'h1234, 16'h0, 16'h0);
`endif

    // two reads on consecutive cycles: bursts separated by one idle cycle
    vmask = '0; d8 = '0; d9 = '0; d11 = '0; d12 = '0;
    burst_length_div2 = 3'd2;
    app_af_addr = {1'b0, CMD_READ, 32'h20};
    app_af_wren = 1'b1;
    @(negedge clk);
    app_af_addr = {1'b0, CMD_READ, 32'hFF};
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      app_af_wren = 1'b0;
      vmask[c] = read_data_valid;
      if (c == 8)  d8  = read_data_fifo_out;
      if (c == 9)  d9  = read_data_fifo_out;
      if (c == 11) d11 = read_data_fifo_out;
      if (c == 12) d12 = read_data_fifo_out;
    end
    check("b2b_valid", vmask, 17'h01B00);
    check("b2b_d0", d8, 16'hAA11);
    check("b2b_d1", d9, 16'hBB22);
    check("b2b_d2", d11, 16'h1111);
    check("b2b_d3", d12, 16'h2222);
    repeat (4) @(negedge clk);

    // reset in the middle of a read burst
    burst_length_div2 = 3'd4;
    app_af_addr = {1'b0, CMD_READ, 32'hFF};
    app_af_wren = 1'b1;
    @(negedge clk);
    app_af_wren = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rdv_pre", read_data_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rdv_drop", read_data_valid, 0);
    check("mid_data_clr", read_data_fifo_out, 0);
    check("mid_init_clr", init_done, 0);
    check("mid_af_afull", af_almost_full, 1);
    @(negedge clk);
    @(negedge clk);

    // INIT reruns; pushes are buffered meanwhile
    burst_length_div2 = 3'd2;
    app_af_addr = {1'b0, CMD_READ, 32'h0};
    app_wdf_data = 16'h5A5A;
    app_mask_data = 2'b00;
    reset_n = 1'b1;
    app_af_wren = 1'b1;
    app_wdf_wren = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      app_af_wren  = (c + 1 <= 17);
      app_wdf_wren = (c + 1 <= 24);
      if (c == 1)   check("re_wdf_afull_low", wdf_almost_full, 0);
      if (c == 12)  check("af_afull_12", af_almost_full, 0);
      if (c == 13)  check("af_afull_13", af_almost_full, 1);
      if (c == 16)  check("ovf_16", overflow_err, 0);
      if (c == 17)  check("ovf_17", overflow_err, 1);
      if (c == 24)  check("wdf_afull_24", wdf_almost_full, 0);
      if (c == 25)  check("wdf_afull_25", wdf_almost_full, 1);
      if (c == 255) check("reinit_255", init_done, 0);
      if (c == 256) check("reinit_256", init_done, 1);
    end
    beats = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (read_data_valid) beats++;
    end
    check("buffered_beats", beats, 32);
    check("ovf_sticky", overflow_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
